// File: rtl/star_collect.sv
// Star pickup logic: two independent star FSMs (alive / hit / dead with frame-counted
// respawn) plus a saturating two-digit BCD score and a collection strobe.
module star_fsm #(
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic hit_req,
  output logic alive,
  output logic collect
);
  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_e;

  localparam logic [7:0] RESPAWN = 8'(RESPAWN_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       alive_q;

  // A star is only scored on the frame boundary that ends its HIT window.
  assign collect = (state_q == HIT) && frame_tick;
  assign alive   = alive_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ALIVE: if (hit_req) state_d = HIT;
      HIT: if (frame_tick) begin
        state_d = DEAD;
        cnt_d   = RESPAWN;
      end
      DEAD: if (frame_tick) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ALIVE;
      end
      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIVE;
      cnt_q   <= 8'd0;
      alive_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alive_q <= (state_d != DEAD);
    end
  end
endmodule

module star_collect #(
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_sync,
  input  logic       game_active,
  input  logic       player_on,
  input  logic       star1_on,
  input  logic       star2_on,
  output logic       s1_alive,
  output logic       s2_alive,
  output logic [7:0] score,
  output logic       collect_pulse
);
  localparam int NUM_STARS = 2;

  logic                 v_d_q;
  logic                 frame_tick;
  logic [NUM_STARS-1:0] star_on, hit_req, alive, collect;
  logic [7:0]           score_q, score_d;
  logic                 collect_pulse_q, collect_pulse_d;
  logic [1:0]           n_collect;
  logic [4:0]           ones_sum, tens_sum;

  assign frame_tick = v_sync & ~v_d_q;
  assign star_on    = {star2_on, star1_on};
  assign hit_req    = {NUM_STARS{game_active & player_on}} & star_on;

  for (genvar i = 0; i < NUM_STARS; i++) begin : g_star
    star_fsm #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_star (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .hit_req    (hit_req[i]),
      .alive      (alive[i]),
      .collect    (collect[i])
    );
  end

  // BCD add of 0..2 with saturation once the tens digit would overflow.
  always_comb begin
    n_collect = {1'b0, collect[0]} + {1'b0, collect[1]};
    ones_sum  = {1'b0, score_q[3:0]} + {3'b0, n_collect};
    tens_sum  = {1'b0, score_q[7:4]};
    if (ones_sum > 5'd9) begin
      ones_sum = ones_sum - 5'd10;
      tens_sum = tens_sum + 5'd1;
    end
    if (tens_sum > 5'd9) score_d = 8'h99;
    else                 score_d = {tens_sum[3:0], ones_sum[3:0]};
    collect_pulse_d = |collect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_d_q           <= 1'b1;
      score_q         <= 8'h00;
      collect_pulse_q <= 1'b0;
    end else begin
      v_d_q           <= v_sync;
      score_q         <= score_d;
      collect_pulse_q <= collect_pulse_d;
    end
  end

  assign s1_alive      = alive[0];
  assign s2_alive      = alive[1];
  assign score         = score_q;
  assign collect_pulse = collect_pulse_q;
endmodule

// File: tb/tb_star_collect.sv
// Randomized + directed bench for star_collect; a frame-level reference model feeds a
// per-cycle scoreboard that a separate monitor drains and compares against the DUT.
module tb_star_collect;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v_sync = 1'b0;
  logic       game_active = 1'b1;
  logic       player_on = 1'b0;
  logic       star1_on = 1'b0;
  logic       star2_on = 1'b0;
  logic       s1_alive, s2_alive, collect_pulse;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  star_collect #(.RESPAWN_FRAMES(R)) dut (
    .clk(clk), .rst(rst), .v_sync(v_sync), .game_active(game_active),
    .player_on(player_on), .star1_on(star1_on), .star2_on(star2_on),
    .s1_alive(s1_alive), .s2_alive(s2_alive), .score(score),
    .collect_pulse(collect_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each star: 0 = drawable and untouched, 1 = touched (collect pending),
  // 2 = collected and counting frame boundaries until it reappears.
  typedef struct packed {
    logic       s1;
    logic       s2;
    logic [7:0] sc;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   m_phase [2];
  int   m_dead_seen [2];
  int   m_score_dec = 0;
  bit   m_vprev = 1'b1;

  always @(posedge clk) begin
    bit tick, on;
    int n;
    exp_t e;
    tick = v_sync && !m_vprev;
    n = 0;
    if (rst) begin
      m_vprev = 1'b1;
      m_score_dec = 0;
      for (int s = 0; s < 2; s++) begin m_phase[s] = 0; m_dead_seen[s] = 0; end
    end else begin
      m_vprev = v_sync;
      for (int s = 0; s < 2; s++) begin
        on = (s == 0) ? star1_on : star2_on;
        if (m_phase[s] == 0) begin
          if (game_active && player_on && on) m_phase[s] = 1;
        end else if (m_phase[s] == 1) begin
          if (tick) begin m_phase[s] = 2; m_dead_seen[s] = 0; n++; end
        end else if (tick) begin
          m_dead_seen[s]++;
          if (m_dead_seen[s] == R) m_phase[s] = 0;
        end
      end
      m_score_dec = (m_score_dec + n > 99) ? 99 : m_score_dec + n;
    end
    e.s1    = (m_phase[0] != 2);
    e.s2    = (m_phase[1] != 2);
    e.sc    = {4'(m_score_dec / 10), 4'(m_score_dec % 10)};
    e.pulse = (n > 0);
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      a = '{s1: s1_alive, s2: s2_alive, sc: score, pulse: collect_pulse};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t got s1=%b s2=%b score=%h pulse=%b want s1=%b s2=%b score=%h pulse=%b",
                 $time, a.s1, a.s2, a.sc, a.pulse, e.s1, e.s2, e.sc, e.pulse);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic frame();
    v_sync = 1'b1; step(2);
    v_sync = 1'b0; step(2);
  endtask

  task automatic overlap(input logic a, input logic b);
    player_on = 1'b1; star1_on = a; star2_on = b; step(1);
    player_on = 1'b0; star1_on = 1'b0; star2_on = 1'b0;
  endtask

  // Collect the chosen stars and wait until they are drawable again.
  task automatic collect_full(input logic a, input logic b);
    overlap(a, b);
    frame();
    repeat (R) frame();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] sc0;
    step(3);
    chk("reset_score", score, 8'h00);
    chk("reset_alive", {6'd0, s2_alive, s1_alive}, 8'h03);
    chk("reset_pulse", {7'd0, collect_pulse}, 8'h00);
    rst = 1'b0; step(2);

    // single collect of star 1
    overlap(1'b1, 1'b0);
    step(2);
    chk("hit_still_alive", {7'd0, s1_alive}, 8'h01);
    v_sync = 1'b1; step(1);
    chk("single_score", score, 8'h01);
    chk("single_pulse", {7'd0, collect_pulse}, 8'h01);
    chk("single_s1_dead", {6'd0, s2_alive, s1_alive}, 8'h02);
    step(1);
    chk("single_pulse_one_clk", {7'd0, collect_pulse}, 8'h00);
    v_sync = 1'b0; step(2);
    frame(); frame();
    chk("s1_dead_before_3rd", {7'd0, s1_alive}, 8'h00);
    v_sync = 1'b1; step(1);
    chk("s1_respawn", {7'd0, s1_alive}, 8'h01);
    v_sync = 1'b0; step(2);

    // preload to 0x09, then both stars at once for the BCD carry
    repeat (8) collect_full(1'b1, 1'b0);
    chk("preload_09", score, 8'h09);
    overlap(1'b1, 1'b1);
    v_sync = 1'b1; step(1);
    chk("dual_carry", score, 8'h11);
    chk("dual_pulse", {7'd0, collect_pulse}, 8'h01);
    step(1);
    chk("dual_single_pulse", {7'd0, collect_pulse}, 8'h00);
    v_sync = 1'b0; step(2);
    repeat (R) frame();

    // long overlap within one frame scores once
    sc0 = score;
    player_on = 1'b1; star2_on = 1'b1; step(500);
    player_on = 1'b0; star2_on = 1'b0;
    frame();
    chk("long_overlap_once", score, sc0 + 8'h01);
    repeat (R) frame();

    // gated overlap does nothing
    game_active = 1'b0;
    sc0 = score;
    overlap(1'b1, 1'b1);
    frame();
    chk("gated_score", score, sc0);
    chk("gated_alive", {6'd0, s2_alive, s1_alive}, 8'h03);
    game_active = 1'b1;

    // climb to 0x98 then check saturation
    for (int k = 0; k < 60 && score < 8'h97; k++) collect_full(1'b1, 1'b1);
    for (int k = 0; k < 4 && score < 8'h98; k++) collect_full(1'b1, 1'b0);
    chk("reach_98", score, 8'h98);
    collect_full(1'b1, 1'b1);
    chk("sat_99", score, 8'h99);
    collect_full(1'b1, 1'b1);
    chk("sat_hold", score, 8'h99);

    // reset while star 1 is in HIT, v_sync held high across release
    do_reset(); step(1);
    overlap(1'b1, 1'b0);
    v_sync = 1'b1; rst = 1'b1; step(2); rst = 1'b0; step(4);
    chk("rst_hit_score", score, 8'h00);
    chk("rst_hit_alive", {7'd0, s1_alive}, 8'h01);
    overlap(1'b1, 1'b0);
    step(4);
    chk("no_spurious_tick", score, 8'h00);
    v_sync = 1'b0; step(2); v_sync = 1'b1; step(1);
    chk("tick_after_reedge", score, 8'h01);
    v_sync = 1'b0; step(2);

    // randomized phase; monitor checks every cycle against the model
    for (int k = 0; k < 4000; k++) begin
      v_sync      = ($urandom_range(0, 5) == 0) ? ~v_sync : v_sync;
      game_active = ($urandom_range(0, 7) != 0);
      player_on   = $urandom_range(0, 1);
      star1_on    = ($urandom_range(0, 3) == 0);
      star2_on    = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0; player_on = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/star_collect.md
STAR_COLLECT -- requirements
Module: star_collect

Interface
REQ-001 SHALL have parameter RESPAWN_FRAMES, default 60, meaning the number of frame ticks a collected star stays dead (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single pixel clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port v_sync, input, 1 bit: the VGA vertical sync level; its rising edge marks the frame boundary.
REQ-005 SHALL have port game_active, input, 1 bit: when low, the block registers no hits.
REQ-006 SHALL have port player_on, input, 1 bit: the player sprite covers the current pixel.
REQ-007 SHALL have port star1_on, input, 1 bit: the star 1 shape covers the current pixel.
REQ-008 SHALL have port star2_on, input, 1 bit: the star 2 shape covers the current pixel.
REQ-009 SHALL have port s1_alive, output, 1 bit: star 1 is drawable; this feeds the star renderer.
REQ-010 SHALL have port s2_alive, output, 1 bit: star 2 is drawable.
REQ-011 SHALL have port score, output, 8 bits: a two-digit BCD collected-star count, tens digit in [7:4] and ones digit in [3:0].
REQ-012 SHALL have port collect_pulse, output, 1 bit: a one-clock strobe on any collection.

Function
REQ-013 SHALL register v_sync into v_d every clock and define frame_tick = v_sync AND NOT v_d, evaluated combinationally in the current cycle.
REQ-014 SHALL implement one independent FSM per star with states ALIVE, HIT and DEAD.
REQ-015 SHALL drive sN_alive = 1 in ALIVE and in HIT, and 0 in DEAD, with the output registered.
REQ-016 In ALIVE, SHALL go to HIT on a clock where game_active, player_on and starN_on are all 1; a coincident frame_tick does not change this outcome.
REQ-017 In HIT, SHALL stay in HIT until frame_tick, then go to DEAD, load the star's 8-bit respawn counter with RESPAWN_FRAMES, and count one collection.
REQ-018 Additional overlaps while in HIT SHALL NOT add to the score; each star scores at most once per life.
REQ-019 In DEAD, SHALL decrement the counter on each frame_tick; on a frame_tick with counter == 1, SHALL go to ALIVE.
REQ-020 sN_alive SHALL therefore be low for exactly RESPAWN_FRAMES frame boundaries.
REQ-021 In DEAD, SHALL ignore all overlap inputs.
REQ-022 Outputs SHALL change on the clock edge where frame_tick = 1, so they are visible from the next cycle; latency from frame_tick to output is 1 clock.
REQ-023 Score SHALL add the number of stars that went HIT->DEAD on that frame_tick (0, 1 or 2), using BCD carry from ones to tens.
REQ-024 Score SHALL saturate at 0x99; an add of 1 or 2 from 0x98 or 0x99 yields 0x99.
REQ-025 collect_pulse SHALL be 1 for exactly the one clock after a frame_tick on which at least one star went HIT->DEAD; when both stars collect together, it is still a single pulse.
REQ-026 game_active low SHALL block only new ALIVE->HIT transitions.
REQ-027 With game_active low, HIT, DEAD, counters and score SHALL continue to evolve normally.
REQ-028 The block SHALL NOT clear score except through rst.

Reset
REQ-029 On rst, SHALL set both FSMs to ALIVE, s1_alive = s2_alive = 1, both counters to 0, score to 0x00, collect_pulse to 0, and v_d to 1.
REQ-030 Setting v_d to 1 on reset SHALL prevent a high v_sync at reset release from producing a spurious frame_tick.
REQ-031 rst asserted mid-operation, including in HIT or DEAD, SHALL take priority over all other events in that cycle.
REQ-032 Any collection pending in HIT SHALL be discarded by rst and never scored.

Verification
REQ-033 Single collect: with RESPAWN_FRAMES = 3, assert player_on and star1_on together for 1 clock, then apply a frame_tick -> next cycle shows score = 0x01, collect_pulse = 1 for one clock, and s1_alive = 0; s1_alive returns to 1 after the 3rd following frame_tick; s2_alive stays 1 throughout.
REQ-034 Dual collect and BCD carry: preload score to 0x09 via 9 single collects, overlap both stars in one frame, then frame_tick -> score = 0x11 and collect_pulse is a single 1-clock pulse.
REQ-035 Saturation: starting from score = 0x98, collect both stars in one frame -> score = 0x99; collecting again keeps score = 0x99.
REQ-036 Repeated overlap and gating: hold the overlap high for 500 clocks in one frame -> score increases by exactly 1; with game_active = 0, the overlap produces no change to alive or score.
REQ-037 Reset behaviour: assert rst while star1 is in HIT -> after reset, score is unchanged at 0x00 and s1_alive = 1; with v_sync held high across reset release, no frame_tick occurs until v_sync falls and then rises again.
